multicycle_ctrl_fsm: RTL

- Parametrised multi-cycle control unit for the RISC core. It sequences the FETCH / DECODE / EXECUTE / MEM / WRITE_BACK states.
- It decodes op/func into datapath controls and latches them for the whole instruction.
- It handshakes with instruction fetch and data memory, and skips states an instruction does not need.
- It sits between the instruction register and the datapath stage enables, PC mux, stack and register file.

---
 rtl/multicycle_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB and drives datapath controls.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl_fsm #(
  parameter int unsigned FUNC_W      = 5,
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned SKIP_STAGES = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               stop_bit,
  input  logic               zero,
  input  logic               fetch_done,
  input  logic               mem_ready,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               regfile_en,
  output logic               alu_en,
  output logic               mem_en,
  output logic               wb_en,
  output logic [1:0]         pc_src,
  output logic               pc_we,
  output logic               stack_rd,
  output logic               stack_wr,
  output logic               reg_wr,
  output logic               reg_src,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               wb_data,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count,
  output logic [CNT_W-1:0]   stall_count
);

  localparam bit SKIP = (SKIP_STAGES != 0);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               beq;
    logic               reg_wr;
    logic               reg_src;
    logic               mem_rd;
    logic               mem_wr;
    logic               wb_data;
    logic               stack_wr;
    logic               stop;
  } ctrl_t;

  state_t cur_state, nxt_state;
  ctrl_t  ctrl, dec;
  logic   dec_illegal;
  logic   zero_q;
  logic   illegal_q;
  logic   last_cycle;

  // Instruction decode; only captured while in DECODE
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    case (op)
      2'b00: begin
        case (func)
          FUNC_W'(0), FUNC_W'(1), FUNC_W'(2), FUNC_W'(3): begin
            dec.alu_op = ALUOP_W'(func);
            dec.reg_wr = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        case (func)
          FUNC_W'(0): begin
            dec.alu_op = ALUOP_W'(4);
            dec.reg_wr = 1'b1;
          end
          FUNC_W'(1): begin
            dec.alu_op = ALUOP_W'(5);
            dec.reg_wr = 1'b1;
          end
          FUNC_W'(2): begin
            dec.alu_op  = ALUOP_W'(6);
            dec.reg_wr  = 1'b1;
            dec.mem_rd  = 1'b1;
            dec.wb_data = 1'b1;
          end
          FUNC_W'(3): begin
            dec.alu_op = ALUOP_W'(7);
            dec.mem_wr = 1'b1;
          end
          FUNC_W'(4): begin
            dec.alu_op = ALUOP_W'(8);
            dec.beq    = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (func)
          FUNC_W'(0): begin
            dec.alu_op = ALUOP_W'(9);
            dec.pc_src = 2'b10;
          end
          FUNC_W'(1): begin
            dec.alu_op   = ALUOP_W'(10);
            dec.pc_src   = 2'b10;
            dec.stack_wr = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: begin
        case (func)
          FUNC_W'(0), FUNC_W'(1): begin
            dec.alu_op  = (func == FUNC_W'(0)) ? ALUOP_W'(11) : ALUOP_W'(12);
            dec.reg_wr  = 1'b1;
            dec.reg_src = 1'b1;
          end
          FUNC_W'(2), FUNC_W'(3): begin
            dec.alu_op = (func == FUNC_W'(2)) ? ALUOP_W'(13) : ALUOP_W'(14);
            dec.reg_wr = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
    dec.stop = stop_bit;
  end

  // State, latched control, branch flag and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      ctrl      <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) begin
        ctrl <= dec;
        if (dec_illegal) illegal_q <= 1'b1;
      end
      if (cur_state == S_EXECUTE) zero_q <= zero;
    end
  end

  // Next state and control outputs; strobes are suppressed while reset is high
  always_comb begin
    nxt_state  = cur_state;
    last_cycle = 1'b0;
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    regfile_en = 1'b0;
    alu_en     = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    pc_src     = ctrl.pc_src;
    pc_we      = 1'b0;
    stack_rd   = 1'b0;
    stack_wr   = 1'b0;
    reg_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;

    case (cur_state)
      S_FETCH: begin
        fetch_en = 1'b1;
        if (fetch_done) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        decode_en  = 1'b1;
        regfile_en = 1'b1;
        nxt_state  = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        if (!SKIP || ctrl.mem_rd || ctrl.mem_wr) nxt_state = S_MEM;
        else if (ctrl.reg_wr)                    nxt_state = S_WB;
        else                                     nxt_state = S_FETCH;
        stack_wr = ctrl.stack_wr;
      end
      S_MEM: begin
        mem_en = 1'b1;
        mem_rd = ctrl.mem_rd;
        mem_wr = ctrl.mem_wr;
        if (mem_ready) nxt_state = (!SKIP || ctrl.mem_rd) ? S_WB : S_FETCH;
      end
      S_WB: begin
        wb_en     = 1'b1;
        reg_wr    = ctrl.reg_wr;
        nxt_state = S_FETCH;
      end
      default: nxt_state = S_FETCH;
    endcase

    // Zero is live in EXECUTE and held from then on for later PC updates
    if (ctrl.stop)     pc_src = 2'b11;
    else if (ctrl.beq) pc_src = {1'b0, (cur_state == S_EXECUTE) ? zero : zero_q};

    last_cycle = (cur_state == S_EXECUTE || cur_state == S_MEM || cur_state == S_WB)
                 && (nxt_state == S_FETCH);
    pc_we      = last_cycle;
    stack_rd   = last_cycle && ctrl.stop;

    if (reset) begin
      pc_we    = 1'b0;
      stack_rd = 1'b0;
      stack_wr = 1'b0;
      reg_wr   = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
    end
  end

  assign state   = cur_state;
  assign alu_op  = ctrl.alu_op;
  assign reg_src = ctrl.reg_src;
  assign wb_data = ctrl.wb_data;
  assign illegal = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instr_q, stall_q;
  logic             stall;

  assign stall = ((cur_state == S_FETCH) && !fetch_done) ||
                 ((cur_state == S_MEM) && !mem_ready);

  // Free-running performance counters, wrapping at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (pc_we) instr_q <= instr_q + CNT_W'(1);
      if (stall) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign stall_count = stall_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
  assign stall_count = '0;
`endif

endmodule
